// File: rtl/skill_pkg.sv
// Shared definitions for the skill scheduler slice.
// Holds skill index constants, the per-skill state encoding and the
// fixed-priority pick used by the arbiter.
package skill_pkg;

    localparam int unsigned NUM_SKILLS = 3;

    localparam int unsigned SK_J = 0;
    localparam int unsigned SK_K = 1;
    localparam int unsigned SK_L = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_COOL   = 2'd2
    } skill_state_e;

    // Keeps only the lowest set bit: J (bit 0) beats K beats L.
    function automatic logic [NUM_SKILLS-1:0] pick_first(input logic [NUM_SKILLS-1:0] v);
        return v & (~v + NUM_SKILLS'(1));
    endfunction

endpackage

// File: rtl/skill_timer.sv
// One skill's IDLE/ACTIVE/COOL state machine and tick counter.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   tick      - game-tick enable; the counter only moves on tick
//   start     - grant pulse from the arbiter (only honoured in IDLE)
//   abort     - forces IDLE and clears the counter on the next edge
//   active    - registered: skill in effect
//   cooling   - registered: skill in cooldown
//   idle      - registered: skill may be granted
module skill_timer
    import skill_pkg::*;
#(
    parameter int unsigned DUR_TICKS = 64,
    parameter int unsigned CD_TICKS  = 16,
    parameter int unsigned TW        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic start,
    input  logic abort,
    output logic active,
    output logic cooling,
    output logic idle
);

    skill_state_e  r_state;
    logic [TW-1:0] r_cnt;

    // A tick seen with the counter at 1 is the tick that takes it to 0,
    // so the state change lands on that same edge.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            active  <= 1'b0;
            cooling <= 1'b0;
            idle    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_ACTIVE;
                        r_cnt   <= TW'(DUR_TICKS);
                        active  <= 1'b1;
                        idle    <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (tick) begin
                        if (r_cnt <= TW'(1)) begin
                            active <= 1'b0;
                            if (CD_TICKS == 0) begin
                                r_state <= ST_IDLE;
                                r_cnt   <= '0;
                                idle    <= 1'b1;
                            end else begin
                                r_state <= ST_COOL;
                                r_cnt   <= TW'(CD_TICKS);
                                cooling <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt - TW'(1);
                        end
                    end
                end
                ST_COOL: begin
                    if (tick) begin
                        if (r_cnt <= TW'(1)) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            cooling <= 1'b0;
                            idle    <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - TW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    active  <= 1'b0;
                    cooling <= 1'b0;
                    idle    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/skill_scheduler.sv
// Skill arbiter for the J/K/L player skills.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   tick         - game-tick enable for all skill timers
//   game_active  - high during play; low aborts every skill
//   req[2:0]     - request pulses, bit0 = J, bit1 = K, bit2 = L
//   refill       - returns one skill point (saturating)
//   grant[2:0]   - one-hot pulse for the accepted request
//   deny         - pulse when any request bit was rejected
//   active[2:0]  - skill in effect
//   cooling[2:0] - skill in cooldown
//   points[1:0]  - remaining skill points
module skill_scheduler
    import skill_pkg::*;
#(
    parameter int unsigned MAX_POINTS = 3,
    parameter int unsigned DUR_TICKS  = 64,
    parameter int unsigned CD_TICKS   = 16,
    parameter int unsigned TW         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  game_active,
    input  logic [NUM_SKILLS-1:0] req,
    input  logic                  refill,
    output logic [NUM_SKILLS-1:0] grant,
    output logic                  deny,
    output logic [NUM_SKILLS-1:0] active,
    output logic [NUM_SKILLS-1:0] cooling,
    output logic [1:0]            points
);

    logic [NUM_SKILLS-1:0] w_idle;
    logic [NUM_SKILLS-1:0] w_elig;
    logic [NUM_SKILLS-1:0] w_grant;
    logic                  w_abort;

    logic [NUM_SKILLS-1:0] r_grant;
    logic                  r_deny;
    logic [1:0]            r_points;

    assign w_abort = !game_active;

    always_comb begin
        w_elig = '0;
        if (game_active && (r_points != 2'd0)) begin
            w_elig = req & w_idle;
        end
        w_grant = pick_first(w_elig);
    end

    for (genvar gi = 0; gi < NUM_SKILLS; gi++) begin : g_timer
        skill_timer #(
            .DUR_TICKS (DUR_TICKS),
            .CD_TICKS  (CD_TICKS),
            .TW        (TW)
        ) u_timer (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .start   (w_grant[gi]),
            .abort   (w_abort),
            .active  (active[gi]),
            .cooling (cooling[gi]),
            .idle    (w_idle[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant  <= '0;
            r_deny   <= 1'b0;
            r_points <= 2'(MAX_POINTS);
        end else begin
            r_grant <= w_grant;
            r_deny  <= |(req & ~w_grant);
            // Grant plus refill in one cycle cancel out; a grant implies points > 0.
            case ({|w_grant, refill})
                2'b10:   r_points <= r_points - 2'd1;
                2'b01: begin
                    if (r_points < 2'(MAX_POINTS)) begin
                        r_points <= r_points + 2'd1;
                    end
                end
                default: r_points <= r_points;
            endcase
        end
    end

    assign grant  = r_grant;
    assign deny   = r_deny;
    assign points = r_points;

endmodule

// File: tb/tb_skill_scheduler.sv
module tb_skill_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       game_active;
    logic [2:0] req;
    logic       refill;
    logic [2:0] grant;
    logic       deny;
    logic [2:0] active;
    logic [2:0] cooling;
    logic [1:0] points;

    skill_scheduler #(
        .MAX_POINTS (3),
        .DUR_TICKS  (64),
        .CD_TICKS   (16),
        .TW         (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .game_active (game_active),
        .req         (req),
        .refill      (refill),
        .grant       (grant),
        .deny        (deny),
        .active      (active),
        .cooling     (cooling),
        .points      (points)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] grant;
        logic       deny;
        logic [2:0] active;
        logic [2:0] cooling;
        logic [1:0] points;
    } exp_t;

    // pre: idle tick cycles inserted before the row's request cycle
    typedef struct {
        int         pre;
        logic       ga;
        logic [2:0] rq;
        logic       rf;
        logic       tk;
        exp_t       e;
    } row_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic step(input logic [2:0] rq, input logic rf, input logic tk);
        req    = rq;
        refill = rf;
        tick   = tk;
        @(posedge clk);
        #1;
        req    = '0;
        refill = 1'b0;
        tick   = 1'b0;
    endtask

    task automatic apply_reset();
        rst         = 1'b1;
        game_active = 1'b1;
        step(3'b000, 1'b0, 1'b0);
        step(3'b000, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t ev;
        rst         = 1'b1;
        game_active = 1'b1;
        step(3'b111, 1'b1, 1'b1);
        step(3'b111, 1'b1, 1'b1);
        sb_q.push_back(exp_t'{3'b000, 1'b0, 3'b000, 3'b000, 2'd3});
        ev = sb_q.pop_front();
        tests_run++;
        if ({grant, deny, active, cooling, points} !== ev) begin
            tests_failed++;
            $display("FAIL reset_state: got g=%b d=%b a=%b c=%b p=%0d, expected g=%b d=%b a=%b c=%b p=%0d",
                     grant, deny, active, cooling, points, ev.grant, ev.deny, ev.active, ev.cooling, ev.points);
        end
        rst = 1'b0;
        step(3'b001, 1'b0, 1'b0);
        step(3'b010, 1'b0, 1'b1);
        // reset mid-operation with a live request
        rst = 1'b1;
        sb_q.push_back(exp_t'{3'b000, 1'b0, 3'b000, 3'b000, 2'd3});
        step(3'b100, 1'b0, 1'b1);
        ev = sb_q.pop_front();
        tests_run++;
        if ({grant, deny, active, cooling, points} !== ev) begin
            tests_failed++;
            $display("FAIL reset_mid_op: got g=%b d=%b a=%b c=%b p=%0d, expected g=%b d=%b a=%b c=%b p=%0d",
                     grant, deny, active, cooling, points, ev.grant, ev.deny, ev.active, ev.cooling, ev.points);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_grant();
        exp_t       ev;
        logic [2:0] exp_a;
        logic [2:0] exp_c;
        apply_reset();
        sb_q.push_back(exp_t'{3'b001, 1'b0, 3'b001, 3'b000, 2'd2});
        step(3'b001, 1'b0, 1'b1);
        ev = sb_q.pop_front();
        tests_run++;
        if ({grant, deny, active, cooling, points} !== ev) begin
            tests_failed++;
            $display("FAIL single_grant: got g=%b d=%b a=%b c=%b p=%0d, expected g=%b d=%b a=%b c=%b p=%0d",
                     grant, deny, active, cooling, points, ev.grant, ev.deny, ev.active, ev.cooling, ev.points);
        end
        for (int t = 1; t <= 82; t++) begin
            step(3'b000, 1'b0, 1'b1);
            exp_a = (t < 64) ? 3'b001 : 3'b000;
            exp_c = (t >= 64 && t < 80) ? 3'b001 : 3'b000;
            tests_run++;
            if ({active, cooling, grant} !== {exp_a, exp_c, 3'b000}) begin
                tests_failed++;
                $display("FAIL timer_tick%0d: got a=%b c=%b g=%b, expected a=%b c=%b g=000",
                         t, active, cooling, grant, exp_a, exp_c);
            end
        end
        tests_run++;
        if (points !== 2'd2) begin
            tests_failed++;
            $display("FAIL points_after_expiry: got %0d, expected 2", points);
        end
    endtask

    task automatic test_multi_req();
        exp_t ev;
        row_t rows[2] = '{
            '{0, 1'b1, 3'b111, 1'b0, 1'b0, exp_t'{3'b001, 1'b1, 3'b001, 3'b000, 2'd2}},
            '{0, 1'b1, 3'b110, 1'b0, 1'b0, exp_t'{3'b010, 1'b1, 3'b011, 3'b000, 2'd1}}
        };
        apply_reset();
        foreach (rows[i]) begin
            repeat (rows[i].pre) step(3'b000, 1'b0, 1'b1);
            game_active = rows[i].ga;
            sb_q.push_back(rows[i].e);
            step(rows[i].rq, rows[i].rf, rows[i].tk);
            ev = sb_q.pop_front();
            tests_run++;
            if ({grant, deny, active, cooling, points} !== ev) begin
                tests_failed++;
                $display("FAIL multi_req[%0d]: got g=%b d=%b a=%b c=%b p=%0d, expected g=%b d=%b a=%b c=%b p=%0d",
                         i, grant, deny, active, cooling, points, ev.grant, ev.deny, ev.active, ev.cooling, ev.points);
            end
        end
    endtask

    task automatic test_exhaust();
        exp_t ev;
        row_t rows[6] = '{
            '{0,  1'b1, 3'b001, 1'b0, 1'b0, exp_t'{3'b001, 1'b0, 3'b001, 3'b000, 2'd2}},
            '{0,  1'b1, 3'b010, 1'b0, 1'b0, exp_t'{3'b010, 1'b0, 3'b011, 3'b000, 2'd1}},
            '{0,  1'b1, 3'b100, 1'b0, 1'b0, exp_t'{3'b100, 1'b0, 3'b111, 3'b000, 2'd0}},
            '{80, 1'b1, 3'b001, 1'b0, 1'b0, exp_t'{3'b000, 1'b1, 3'b000, 3'b000, 2'd0}},
            '{0,  1'b1, 3'b000, 1'b1, 1'b0, exp_t'{3'b000, 1'b0, 3'b000, 3'b000, 2'd1}},
            '{0,  1'b1, 3'b001, 1'b0, 1'b0, exp_t'{3'b001, 1'b0, 3'b001, 3'b000, 2'd0}}
        };
        apply_reset();
        foreach (rows[i]) begin
            repeat (rows[i].pre) step(3'b000, 1'b0, 1'b1);
            game_active = rows[i].ga;
            sb_q.push_back(rows[i].e);
            step(rows[i].rq, rows[i].rf, rows[i].tk);
            ev = sb_q.pop_front();
            tests_run++;
            if ({grant, deny, active, cooling, points} !== ev) begin
                tests_failed++;
                $display("FAIL exhaust[%0d]: got g=%b d=%b a=%b c=%b p=%0d, expected g=%b d=%b a=%b c=%b p=%0d",
                         i, grant, deny, active, cooling, points, ev.grant, ev.deny, ev.active, ev.cooling, ev.points);
            end
        end
    endtask

    task automatic test_refill();
        exp_t ev;
        row_t rows[8] = '{
            '{0, 1'b1, 3'b001, 1'b0, 1'b0, exp_t'{3'b001, 1'b0, 3'b001, 3'b000, 2'd2}},
            '{0, 1'b1, 3'b010, 1'b1, 1'b0, exp_t'{3'b010, 1'b0, 3'b011, 3'b000, 2'd2}},
            '{0, 1'b1, 3'b000, 1'b1, 1'b0, exp_t'{3'b000, 1'b0, 3'b011, 3'b000, 2'd3}},
            '{0, 1'b1, 3'b000, 1'b1, 1'b0, exp_t'{3'b000, 1'b0, 3'b011, 3'b000, 2'd3}},
            '{0, 1'b1, 3'b000, 1'b1, 1'b0, exp_t'{3'b000, 1'b0, 3'b011, 3'b000, 2'd3}},
            '{0, 1'b1, 3'b000, 1'b1, 1'b0, exp_t'{3'b000, 1'b0, 3'b011, 3'b000, 2'd3}},
            '{0, 1'b1, 3'b000, 1'b1, 1'b0, exp_t'{3'b000, 1'b0, 3'b011, 3'b000, 2'd3}},
            '{0, 1'b1, 3'b000, 1'b1, 1'b0, exp_t'{3'b000, 1'b0, 3'b011, 3'b000, 2'd3}}
        };
        apply_reset();
        foreach (rows[i]) begin
            repeat (rows[i].pre) step(3'b000, 1'b0, 1'b1);
            game_active = rows[i].ga;
            sb_q.push_back(rows[i].e);
            step(rows[i].rq, rows[i].rf, rows[i].tk);
            ev = sb_q.pop_front();
            tests_run++;
            if ({grant, deny, active, cooling, points} !== ev) begin
                tests_failed++;
                $display("FAIL refill[%0d]: got g=%b d=%b a=%b c=%b p=%0d, expected g=%b d=%b a=%b c=%b p=%0d",
                         i, grant, deny, active, cooling, points, ev.grant, ev.deny, ev.active, ev.cooling, ev.points);
            end
        end
    endtask

    task automatic test_abort();
        exp_t ev;
        row_t rows[4] = '{
            '{0, 1'b1, 3'b001, 1'b0, 1'b0, exp_t'{3'b001, 1'b0, 3'b001, 3'b000, 2'd2}},
            '{5, 1'b0, 3'b000, 1'b0, 1'b1, exp_t'{3'b000, 1'b0, 3'b000, 3'b000, 2'd2}},
            '{0, 1'b0, 3'b001, 1'b0, 1'b0, exp_t'{3'b000, 1'b1, 3'b000, 3'b000, 2'd2}},
            '{0, 1'b1, 3'b001, 1'b0, 1'b0, exp_t'{3'b001, 1'b0, 3'b001, 3'b000, 2'd1}}
        };
        apply_reset();
        foreach (rows[i]) begin
            repeat (rows[i].pre) step(3'b000, 1'b0, 1'b1);
            game_active = rows[i].ga;
            sb_q.push_back(rows[i].e);
            step(rows[i].rq, rows[i].rf, rows[i].tk);
            ev = sb_q.pop_front();
            tests_run++;
            if ({grant, deny, active, cooling, points} !== ev) begin
                tests_failed++;
                $display("FAIL abort[%0d]: got g=%b d=%b a=%b c=%b p=%0d, expected g=%b d=%b a=%b c=%b p=%0d",
                         i, grant, deny, active, cooling, points, ev.grant, ev.deny, ev.active, ev.cooling, ev.points);
            end
        end
    endtask

    task automatic test_cool_deny();
        exp_t ev;
        row_t rows[2] = '{
            '{0,  1'b1, 3'b001, 1'b0, 1'b0, exp_t'{3'b001, 1'b0, 3'b001, 3'b000, 2'd2}},
            '{64, 1'b1, 3'b011, 1'b0, 1'b0, exp_t'{3'b010, 1'b1, 3'b010, 3'b001, 2'd1}}
        };
        apply_reset();
        foreach (rows[i]) begin
            repeat (rows[i].pre) step(3'b000, 1'b0, 1'b1);
            game_active = rows[i].ga;
            sb_q.push_back(rows[i].e);
            step(rows[i].rq, rows[i].rf, rows[i].tk);
            ev = sb_q.pop_front();
            tests_run++;
            if ({grant, deny, active, cooling, points} !== ev) begin
                tests_failed++;
                $display("FAIL cool_deny[%0d]: got g=%b d=%b a=%b c=%b p=%0d, expected g=%b d=%b a=%b c=%b p=%0d",
                         i, grant, deny, active, cooling, points, ev.grant, ev.deny, ev.active, ev.cooling, ev.points);
            end
        end
    endtask

    task automatic test_cool_boundary();
        exp_t ev;
        // 79 ticks leave J one tick from the end of cooldown; the request
        // rides on the final tick and must still be refused.
        row_t rows[3] = '{
            '{0,  1'b1, 3'b001, 1'b0, 1'b0, exp_t'{3'b001, 1'b0, 3'b001, 3'b000, 2'd2}},
            '{79, 1'b1, 3'b001, 1'b0, 1'b1, exp_t'{3'b000, 1'b1, 3'b000, 3'b000, 2'd2}},
            '{0,  1'b1, 3'b001, 1'b0, 1'b0, exp_t'{3'b001, 1'b0, 3'b001, 3'b000, 2'd1}}
        };
        apply_reset();
        foreach (rows[i]) begin
            repeat (rows[i].pre) step(3'b000, 1'b0, 1'b1);
            game_active = rows[i].ga;
            sb_q.push_back(rows[i].e);
            step(rows[i].rq, rows[i].rf, rows[i].tk);
            ev = sb_q.pop_front();
            tests_run++;
            if ({grant, deny, active, cooling, points} !== ev) begin
                tests_failed++;
                $display("FAIL cool_boundary[%0d]: got g=%b d=%b a=%b c=%b p=%0d, expected g=%b d=%b a=%b c=%b p=%0d",
                         i, grant, deny, active, cooling, points, ev.grant, ev.deny, ev.active, ev.cooling, ev.points);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        tick        = 1'b0;
        game_active = 1'b0;
        req         = '0;
        refill      = 1'b0;
        #1;
        test_reset();
        test_single_grant();
        test_multi_req();
        test_exhaust();
        test_refill();
        test_abort();
        test_cool_deny();
        test_cool_boundary();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
